// File: rtl/rv32_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: forwarding selects, load-use stall, multi-cycle
// busy FSM with watchdog, redirect flush and dmem freeze. Optional perf counters: RV32_HAZARD_PERF_CNT_EN.
module rv32_hazard_ctrl #(
  parameter int REG_ADDR_W    = 5,
  parameter int MC_MAX_CYCLES = 64,
  parameter int CNT_W         = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_mc_start,
  input  logic                  ex_redirect,
  input  logic                  mc_done,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  mem_regwrite,
  input  logic                  wb_regwrite,
  input  logic                  mem_mem_read,
  input  logic                  dmem_wait,
  output logic [1:0]            forward_rs1,
  output logic [1:0]            forward_rs2,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  id_ex_stall,
  output logic                  ex_mem_stall,
  output logic                  mem_wb_stall,
  output logic                  if_id_bubble,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_bubble,
  output logic                  mc_timeout,
  input  logic                  perf_clr,
  output logic [CNT_W-1:0]      perf_lu_stalls,
  output logic [CNT_W-1:0]      perf_mc_stalls,
  output logic [CNT_W-1:0]      perf_flushes,
  output logic                  dbg_busy
);

  localparam int WD_W = 16;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_MAX_CYCLES - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;
  typedef enum logic [2:0] {
    ACT_NONE, ACT_MEM_WAIT, ACT_MC_STALL, ACT_FLUSH, ACT_LOAD_USE
  } action_e;

  state_e          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            load_use;
  logic            wd_expire;
  logic            mc_stall;
  action_e         action;

  // A load in MEM has no data yet, so only non-load MEM results are forwardable.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] m_rd,
    input logic                  m_we,
    input logic                  m_ld,
    input logic [REG_ADDR_W-1:0] w_rd,
    input logic                  w_we
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0) begin
      if (m_we && !m_ld && (rs == m_rd)) sel = 2'b01;
      else if (w_we && (rs == w_rd))    sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    forward_rs1 = 2'b00;
    forward_rs2 = 2'b00;
    if (rst_n) begin
      forward_rs1 = fwd_sel(ex_rs1, mem_rd, mem_regwrite, mem_mem_read, wb_rd, wb_regwrite);
      forward_rs2 = fwd_sel(ex_rs2, mem_rd, mem_regwrite, mem_mem_read, wb_rd, wb_regwrite);
    end
  end

  always_comb begin
    load_use  = ex_mem_read && (ex_rd != '0) &&
                ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
    // The watchdog is frozen by dmem_wait, expiry included.
    wd_expire = (state_q == ST_BUSY) && !mc_done && !dmem_wait && (wd_q == WD_LAST);
    mc_stall  = ((state_q == ST_IDLE) && ex_mc_start && !mc_done) ||
                ((state_q == ST_BUSY) && !mc_done && !wd_expire);
  end

  always_comb begin
    action = ACT_NONE;
    if (!rst_n)            action = ACT_NONE;
    else if (dmem_wait)    action = ACT_MEM_WAIT;
    else if (mc_stall)     action = ACT_MC_STALL;
    else if (ex_redirect)  action = ACT_FLUSH;
    else if (load_use)     action = ACT_LOAD_USE;
  end

  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_stall  = 1'b0;
    if_id_bubble  = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    case (action)
      ACT_MEM_WAIT: begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_stall = 1'b1;
      end
      ACT_MC_STALL: begin
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        id_ex_stall   = 1'b1;
        ex_mem_bubble = 1'b1;
      end
      ACT_FLUSH: begin
        if_id_bubble = 1'b1;
        id_ex_bubble = 1'b1;
      end
      ACT_LOAD_USE: begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  assign mc_timeout = wd_expire;
  assign dbg_busy   = (state_q == ST_BUSY);

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    case (state_q)
      ST_IDLE: begin
        if (ex_mc_start && !mc_done && !dmem_wait) begin
          state_d = ST_BUSY;
          wd_d    = WD_W'(1);
        end
      end
      ST_BUSY: begin
        if (mc_done || wd_expire) begin
          state_d = ST_IDLE;
          wd_d    = '0;
        end else if (!dmem_wait) begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        wd_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

`ifdef RV32_HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q, mc_cnt_q, fl_cnt_q;

  // Saturating counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt_q <= '0;
      mc_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else if (perf_clr) begin
      lu_cnt_q <= '0;
      mc_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      if ((action == ACT_LOAD_USE) && (lu_cnt_q != '1)) lu_cnt_q <= lu_cnt_q + CNT_W'(1);
      if ((action == ACT_MC_STALL) && (mc_cnt_q != '1)) mc_cnt_q <= mc_cnt_q + CNT_W'(1);
      if ((action == ACT_FLUSH) && (fl_cnt_q != '1))    fl_cnt_q <= fl_cnt_q + CNT_W'(1);
    end
  end

  assign perf_lu_stalls = lu_cnt_q;
  assign perf_mc_stalls = mc_cnt_q;
  assign perf_flushes   = fl_cnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign perf_lu_stalls  = '0;
  assign perf_mc_stalls  = '0;
  assign perf_flushes    = '0;
`endif

endmodule

// File: tb/tb_rv32_hazard_ctrl.sv
// Bench for rv32_hazard_ctrl: directed scenarios with constant expectations plus randomized
// cycles checked against a cycle-level reference model of the hazard rules.
module tb_rv32_hazard_ctrl;

  localparam int RW      = 5;
  localparam int MC_MAX  = 8;
  localparam int CW      = 8;
  localparam int CNT_SAT = (1 << CW) - 1;
`ifdef RV32_HAZARD_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  // {fwd1, fwd2, pc, if_id, id_ex, ex_mem, mem_wb stalls, if_id, id_ex, ex_mem bubbles, timeout}
  localparam logic [12:0] V_ALL5  = 13'b00_00_11111_000_0;
  localparam logic [12:0] V_MC    = 13'b00_00_11100_001_0;
  localparam logic [12:0] V_FLUSH = 13'b00_00_00000_110_0;
  localparam logic [12:0] V_LU    = 13'b00_00_11000_010_0;
  localparam logic [12:0] V_TMO   = 13'b00_00_00000_000_1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_rs1_used, id_rs2_used, ex_mem_read, ex_mc_start, ex_redirect, mc_done;
  logic          mem_regwrite, wb_regwrite, mem_mem_read, dmem_wait, perf_clr;
  logic [1:0]    forward_rs1, forward_rs2;
  logic          pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic          if_id_bubble, id_ex_bubble, ex_mem_bubble, mc_timeout, dbg_busy;
  logic [CW-1:0] perf_lu_stalls, perf_mc_stalls, perf_flushes;

  int checks = 0;
  int errors = 0;

  // Reference model state: is a multi-cycle op outstanding, and for how many counted cycles.
  bit m_busy;
  int m_cycles;
  int m_lu, m_mc, m_fl;

  rv32_hazard_ctrl #(.REG_ADDR_W(RW), .MC_MAX_CYCLES(MC_MAX), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_mc_start(ex_mc_start), .ex_redirect(ex_redirect), .mc_done(mc_done),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .mem_mem_read(mem_mem_read), .dmem_wait(dmem_wait),
    .forward_rs1(forward_rs1), .forward_rs2(forward_rs2),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall),
    .if_id_bubble(if_id_bubble), .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
    .mc_timeout(mc_timeout), .perf_clr(perf_clr),
    .perf_lu_stalls(perf_lu_stalls), .perf_mc_stalls(perf_mc_stalls), .perf_flushes(perf_flushes),
    .dbg_busy(dbg_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [1:0] ref_fwd(input logic [RW-1:0] rs);
    if (!rst_n || rs == 0) return 2'b00;
    if (mem_regwrite && !mem_mem_read && rs == mem_rd) return 2'b01;
    if (wb_regwrite && rs == wb_rd) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit ref_timeout();
    return rst_n && m_busy && !mc_done && !dmem_wait && (m_cycles == MC_MAX - 1);
  endfunction

  // 0 none, 1 memory wait, 2 multi-cycle stall, 3 flush, 4 load-use
  function automatic int ref_action();
    bit lu, ms;
    lu = ex_mem_read && ex_rd != 0 &&
         ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    ms = (!m_busy && ex_mc_start && !mc_done) || (m_busy && !mc_done && !ref_timeout());
    if (!rst_n)      return 0;
    if (dmem_wait)   return 1;
    if (ms)          return 2;
    if (ex_redirect) return 3;
    if (lu)          return 4;
    return 0;
  endfunction

  function automatic logic [12:0] ref_vec();
    logic [12:0] v;
    case (ref_action())
      1: v = V_ALL5;
      2: v = V_MC;
      3: v = V_FLUSH;
      4: v = V_LU;
      default: v = 13'd0;
    endcase
    v[12:11] = ref_fwd(ex_rs1);
    v[10:9]  = ref_fwd(ex_rs2);
    v[0]     = ref_timeout();
    return v;
  endfunction

  function automatic logic [12:0] dut_vec();
    return {forward_rs1, forward_rs2, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
            mem_wb_stall, if_id_bubble, id_ex_bubble, ex_mem_bubble, mc_timeout};
  endfunction

  function automatic int sat_inc(input int v);
    return (v < CNT_SAT) ? v + 1 : v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_rs1_used, id_rs2_used, ex_mem_read, ex_mc_start, ex_redirect, mc_done} = '0;
    {mem_regwrite, wb_regwrite, mem_mem_read, dmem_wait, perf_clr} = '0;
  endtask

  // Clock edge with the model stepped on the same (pre-edge) inputs.
  task automatic advance();
    int  act;
    bit  tmo;
    act = ref_action();
    tmo = ref_timeout();
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 0; m_cycles = 0; m_lu = 0; m_mc = 0; m_fl = 0;
    end else begin
      if (PERF_EN) begin
        if (perf_clr) begin
          m_lu = 0; m_mc = 0; m_fl = 0;
        end else begin
          if (act == 4) m_lu = sat_inc(m_lu);
          if (act == 2) m_mc = sat_inc(m_mc);
          if (act == 3) m_fl = sat_inc(m_fl);
        end
      end
      if (!m_busy) begin
        if (ex_mc_start && !mc_done && !dmem_wait) begin
          m_busy = 1; m_cycles = 1;
        end
      end else if (mc_done || tmo) begin
        m_busy = 0; m_cycles = 0;
      end else if (!dmem_wait) begin
        m_cycles++;
      end
    end
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [12:0] obs;
    idle_inputs();
    rst_n = 1'b0;
    dmem_wait = 1'b1; ex_redirect = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3;
    id_rs1 = 5'd3; id_rs1_used = 1'b1; ex_rs1 = 5'd2; mem_rd = 5'd2; mem_regwrite = 1'b1;
    m_busy = 0; m_cycles = 0; m_lu = 0; m_mc = 0; m_fl = 0;
    #2;
    obs = dut_vec();
    checks++;
    if (obs !== 13'd0) begin
      errors++; $display("FAIL reset_outputs: got %b want %b", obs, 13'd0);
    end
    checks++;
    if ({perf_lu_stalls, perf_mc_stalls, perf_flushes, dbg_busy} !== '0) begin
      errors++; $display("FAIL reset_counters: got %0d %0d %0d busy=%0b want 0 0 0 busy=0",
                         perf_lu_stalls, perf_mc_stalls, perf_flushes, dbg_busy);
    end
    advance();
    advance();
    idle_inputs();
    rst_n = 1'b1;
    advance();
  endtask

  task automatic test_forwarding();
    logic [1:0] want [4] = '{2'b01, 2'b10, 2'b00, 2'b10};
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      ex_rs1 = 5'd5; mem_rd = 5'd5; mem_regwrite = 1'b1; wb_rd = 5'd5; wb_regwrite = 1'b1;
      mem_mem_read = (i == 1);
      if (i == 2) ex_rs1 = 5'd0;
      if (i == 3) begin mem_rd = 5'd9; ex_rs2 = 5'd5; end
      #3;
      checks++;
      if (forward_rs1 !== want[i]) begin
        errors++; $display("FAIL fwd_rs1_case%0d: got %b want %b", i, forward_rs1, want[i]);
      end
      if (i == 3) begin
        checks++;
        if (forward_rs2 !== 2'b10) begin
          errors++; $display("FAIL fwd_rs2_wb: got %b want 10", forward_rs2);
        end
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    logic [12:0] obs;
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      if (c == 0) begin ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_rs2_used = 1; end
      if (c == 1) begin ex_mem_read = 0; ex_rd = 0; mem_rd = 7; mem_regwrite = 1; mem_mem_read = 1; end
      if (c == 2) begin idle_inputs(); ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_rs2_used = 0; end
      #3;
      obs = dut_vec();
      checks++;
      if (obs !== ((c == 0) ? V_LU : 13'd0)) begin
        errors++; $display("FAIL load_use_cycle%0d: got %b want %b", c, obs, (c == 0) ? V_LU : 13'd0);
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_mc_op();
    logic [12:0] obs;
    idle_inputs();
    ex_mc_start = 1;
    for (int c = 0; c < 5; c++) begin
      mc_done = (c == 4);
      #3;
      obs = dut_vec();
      checks++;
      if (obs !== ((c < 4) ? V_MC : 13'd0)) begin
        errors++; $display("FAIL mc_cycle%0d: got %b want %b", c, obs, (c < 4) ? V_MC : 13'd0);
      end
      advance();
    end
    ex_mc_start = 1; mc_done = 1;
    #3;
    obs = dut_vec();
    checks++;
    if (obs !== 13'd0 || dbg_busy !== 1'b0) begin
      errors++; $display("FAIL mc_single_cycle: got %b busy=%0b want %b busy=0", obs, dbg_busy, 13'd0);
    end
    advance();
    idle_inputs();
    #3;
    checks++;
    if (dbg_busy !== 1'b0) begin
      errors++; $display("FAIL mc_idle_after: got busy=%0b want 0", dbg_busy);
    end
    advance();
  endtask

  task automatic test_watchdog();
    logic [12:0] obs;
    idle_inputs();
    ex_mc_start = 1;
    for (int c = 0; c < 9; c++) begin
      if (c == 8) ex_mc_start = 0;
      #3;
      obs = dut_vec();
      checks++;
      if (obs !== ((c < 7) ? V_MC : (c == 7) ? V_TMO : 13'd0)) begin
        errors++; $display("FAIL watchdog_cycle%0d: got %b want %b", c, obs,
                           (c < 7) ? V_MC : (c == 7) ? V_TMO : 13'd0);
      end
      advance();
    end
    #3;
    checks++;
    if (dbg_busy !== 1'b0) begin
      errors++; $display("FAIL watchdog_idle: got busy=%0b want 0", dbg_busy);
    end
    advance();
  endtask

  task automatic test_priority();
    logic [12:0] obs;
    idle_inputs();
    ex_redirect = 1; ex_mem_read = 1; ex_rd = 4; id_rs1 = 4; id_rs1_used = 1;
    for (int c = 0; c < 3; c++) begin
      dmem_wait = (c == 0);
      if (c == 2) ex_mc_start = 1;
      #3;
      obs = dut_vec();
      checks++;
      if (obs !== ((c == 0) ? V_ALL5 : (c == 1) ? V_FLUSH : V_MC)) begin
        errors++; $display("FAIL priority_cycle%0d: got %b want %b", c, obs,
                           (c == 0) ? V_ALL5 : (c == 1) ? V_FLUSH : V_MC);
      end
      if (c < 2) advance();
    end
    mc_done = 1;
    advance();
    idle_inputs();
    advance();
  endtask

  task automatic test_reset_mid_busy();
    logic [12:0] obs;
    idle_inputs();
    ex_mc_start = 1;
    advance();
    advance();
    #2;
    rst_n = 1'b0;
    #1;
    obs = dut_vec();
    checks++;
    if (obs !== 13'd0 || dbg_busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_busy: got %b busy=%0b want %b busy=0", obs, dbg_busy, 13'd0);
    end
    checks++;
    if ({perf_lu_stalls, perf_mc_stalls, perf_flushes} !== '0) begin
      errors++; $display("FAIL reset_mid_busy_counters: got %0d %0d %0d want 0 0 0",
                         perf_lu_stalls, perf_mc_stalls, perf_flushes);
    end
    m_busy = 0; m_cycles = 0; m_lu = 0; m_mc = 0; m_fl = 0;
    idle_inputs();
    advance();
    rst_n = 1'b1;
    advance();
  endtask

  task automatic test_perf();
    idle_inputs();
    ex_mem_read = 1; ex_rd = 6; id_rs1 = 6; id_rs1_used = 1;
    for (int c = 0; c < 3; c++) advance();
    idle_inputs(); ex_redirect = 1;
    for (int c = 0; c < 2; c++) advance();
    idle_inputs(); ex_mc_start = 1;
    for (int c = 0; c < 3; c++) begin mc_done = (c == 2); advance(); end
    idle_inputs();
    #3;
    checks++;
    if (perf_lu_stalls !== CW'(m_lu) || perf_mc_stalls !== CW'(m_mc) || perf_flushes !== CW'(m_fl)) begin
      errors++; $display("FAIL perf_counts: got %0d %0d %0d want %0d %0d %0d",
                         perf_lu_stalls, perf_mc_stalls, perf_flushes, m_lu, m_mc, m_fl);
    end
    ex_mem_read = 1; ex_rd = 6; id_rs1 = 6; id_rs1_used = 1;
    for (int c = 0; c < 260; c++) advance();
    #3;
    checks++;
    if (perf_lu_stalls !== CW'(m_lu)) begin
      errors++; $display("FAIL perf_saturate: got %0d want %0d", perf_lu_stalls, m_lu);
    end
    perf_clr = 1;
    advance();
    idle_inputs();
    #3;
    checks++;
    if ({perf_lu_stalls, perf_mc_stalls, perf_flushes} !== '0) begin
      errors++; $display("FAIL perf_clr: got %0d %0d %0d want 0 0 0",
                         perf_lu_stalls, perf_mc_stalls, perf_flushes);
    end
    advance();
  endtask

  task automatic test_random();
    logic [12:0] obs, exp;
    for (int c = 0; c < 400; c++) begin
      id_rs1 = RW'($urandom_range(0, 3)); id_rs2 = RW'($urandom_range(0, 3));
      ex_rs1 = RW'($urandom_range(0, 3)); ex_rs2 = RW'($urandom_range(0, 3));
      ex_rd  = RW'($urandom_range(0, 3)); mem_rd = RW'($urandom_range(0, 3));
      wb_rd  = RW'($urandom_range(0, 3));
      id_rs1_used  = 1'($urandom_range(0, 1)); id_rs2_used  = 1'($urandom_range(0, 1));
      mem_regwrite = 1'($urandom_range(0, 1)); wb_regwrite  = 1'($urandom_range(0, 1));
      mem_mem_read = 1'($urandom_range(0, 1));
      ex_mem_read  = ($urandom_range(0, 9) < 3);
      ex_redirect  = ($urandom_range(0, 9) < 2);
      dmem_wait    = ($urandom_range(0, 9) < 1);
      ex_mc_start  = m_busy ? 1'b1 : ($urandom_range(0, 9) < 1);
      mc_done      = ($urandom_range(0, 9) < 1);
      perf_clr     = ($urandom_range(0, 29) < 1);
      #3;
      exp = ref_vec();
      obs = dut_vec();
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL random_cycle%0d: got %b want %b", c, obs, exp);
      end
      checks++;
      if (dbg_busy !== m_busy || perf_lu_stalls !== CW'(m_lu) ||
          perf_mc_stalls !== CW'(m_mc) || perf_flushes !== CW'(m_fl)) begin
        errors++; $display("FAIL random_state%0d: got busy=%0b %0d %0d %0d want busy=%0b %0d %0d %0d",
                           c, dbg_busy, perf_lu_stalls, perf_mc_stalls, perf_flushes,
                           m_busy, m_lu, m_mc, m_fl);
      end
      advance();
    end
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_mc_op();
    test_watchdog();
    test_priority();
    test_reset_mid_busy();
    test_perf();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
